// File: rtl/axis_testpattern_arbiter_pkg.sv
// Shared types and width helpers for the test-pattern arbiter.
// Used by axis_testpattern_arbiter and axis_rr_picker.
package axis_testpattern_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int NUM_SRC_MIN = 2;
  localparam int NUM_SRC_MAX = 8;

  function automatic int cnt_width(input int burst_len);
    return $clog2(burst_len + 1);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_testpattern_arbiter_if.sv
// AXI-Stream bundle, N lanes wide; tid only with AXIS_ARB_TID_EN.
// master drives data/valid/last, slave drives ready.
interface axis_if #(
  parameter int N   = 1,
  parameter int W   = 24,
  parameter int IDW = 3
);
  logic [N*W-1:0] tdata;
  logic [N-1:0]   tvalid;
  logic [N-1:0]   tready;
  logic           tlast;
`ifdef AXIS_ARB_TID_EN
  logic [IDW-1:0] tid;
`endif

  modport master (
    output tdata, tvalid, tlast,
`ifdef AXIS_ARB_TID_EN
    output tid,
`endif
    input  tready
  );

  modport slave (
    input  tdata, tvalid, tlast,
`ifdef AXIS_ARB_TID_EN
    input  tid,
`endif
    output tready
  );
endinterface

// File: rtl/axis_testpattern_arbiter_rr_picker.sv
// Round-robin search: first request after last, wrapping mod N.
// Purely combinational.
module axis_rr_picker
  import axis_testpattern_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] j;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = '0;
    for (int i = 1; i <= N; i++) begin
      j = IW'((int'(last) + i) % N);
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = j;
      end
    end
  end

endmodule

// File: rtl/axis_testpattern_arbiter.sv
// Round-robin burst arbiter over NUM_SRC pattern streams.
// Optional tid output: define AXIS_ARB_TID_EN.
module axis_testpattern_arbiter
  import axis_testpattern_pkg::*;
#(
  parameter int NUM_SRC     = 2,
  parameter int TDATA_WIDTH = 24,
  parameter int BURST_LEN   = 16,
  parameter int ID_WIDTH    = 3
) (
  input  logic               m_axis_aclk,
  input  logic               m_axis_aresetn,
  input  logic               enable,
  input  logic [NUM_SRC-1:0] src_mask,
  axis_if.slave              s_axis,
  axis_if.master             m_axis,
  output logic               busy
);

  localparam int CNT_W = cnt_width(BURST_LEN);
  localparam int IDX_W = idx_width(NUM_SRC);
  localparam logic [CNT_W-1:0] LAST_BEAT =
    CNT_W'(BURST_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_SRC =
    IDX_W'(NUM_SRC - 1);

  if (NUM_SRC < NUM_SRC_MIN || NUM_SRC > NUM_SRC_MAX)
  begin : g_bad_num_src
    $error("NUM_SRC out of range");
  end
  if ((1 << ID_WIDTH) < NUM_SRC) begin : g_bad_id_w
    $error("ID_WIDTH too small");
  end
  if (BURST_LEN < 1 || BURST_LEN > 65535) begin : g_bad_bl
    $error("BURST_LEN out of range");
  end

  state_t               state;
  logic [IDX_W-1:0]     grant;
  logic [IDX_W-1:0]     last_grant;
  logic [IDX_W-1:0]     nxt;
  logic                 found;
  logic [CNT_W-1:0]     beat_cnt;
  logic [TDATA_WIDTH-1:0] m_data;
  logic                 m_valid;
  logic                 m_last;
  logic [NUM_SRC-1:0]   s_ready;
  logic                 ready_any;
  logic                 accept;

  axis_rr_picker #(
    .N  (NUM_SRC),
    .IW (IDX_W)
  ) u_pick (
    .req   (s_axis.tvalid & src_mask),
    .last  (last_grant),
    .found (found),
    .idx   (nxt)
  );

  // Output register is free, or drains this cycle.
  assign ready_any = ~m_valid | m_axis.tready[0];

  always_comb begin
    s_ready = '0;
    if (m_axis_aresetn && state == GRANT)
      s_ready[grant] = ready_any;
  end

  assign accept = (state == GRANT)
                & s_axis.tvalid[grant]
                & ready_any;

  always_ff @(posedge m_axis_aclk) begin
    if (!m_axis_aresetn) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= LAST_SRC;
      beat_cnt   <= '0;
      m_data     <= '0;
      m_valid    <= 1'b0;
      m_last     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      if (m_valid && m_axis.tready[0])
        m_valid <= 1'b0;
      if (accept) begin
        m_data  <= s_axis.tdata[grant*TDATA_WIDTH +: TDATA_WIDTH];
        m_valid <= 1'b1;
        m_last  <= (beat_cnt == LAST_BEAT);
      end
      unique case (state)
        IDLE: begin
          if (enable && found) begin
            grant      <= nxt;
            last_grant <= nxt;
            beat_cnt   <= '0;
            state      <= GRANT;
            busy       <= 1'b1;
          end
        end
        GRANT: begin
          if (accept) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == LAST_BEAT) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AXIS_ARB_TID_EN
  logic [ID_WIDTH-1:0] m_id;

  always_ff @(posedge m_axis_aclk) begin
    if (!m_axis_aresetn)
      m_id <= '0;
    else if (accept)
      m_id <= ID_WIDTH'(grant);
  end

  assign m_axis.tid = m_id;
`endif

  assign m_axis.tdata  = m_data;
  assign m_axis.tvalid = m_valid;
  assign m_axis.tlast  = m_last;
  assign s_axis.tready = s_ready;

endmodule

// File: doc/axis_testpattern_arbiter.md
# axis_testpattern_arbiter

Round-robin AXI-Stream arbiter and sequencer sharing one master stream between NUM_SRC test-pattern generator outputs. Grants one source at a time for a fixed burst of BURST_LEN beats, marks the final beat with tlast and tags beats with the source index. Sits between the axis_testpattern_generator instances and the downstream consumer (DMA/FIFO). It also owns the global pause/mask control of the pattern sources.

## Interface
- NUM_SRC, 2: number of slave streams, legal 2..8
- TDATA_WIDTH, 24: data width of every stream
- BURST_LEN, 16: beats per grant, legal 1..65535
- ID_WIDTH, 3: m_axis_tid width, must satisfy 2^ID_WIDTH >= NUM_SRC
- m_axis_aclk  in  1  single clock for all logic
- m_axis_aresetn  in  1  synchronous, active-low reset
- enable  in  1  1 = new grants allowed; 0 = finish current burst, then hold idle
- src_mask  in  NUM_SRC  bit i = 1 makes source i eligible for grant
- s_axis_tdata  in  NUM_SRC*TDATA_WIDTH  source i occupies bits [i*TDATA_WIDTH +: TDATA_WIDTH]
- s_axis_tvalid  in  NUM_SRC  per-source valid
- s_axis_tready  out  NUM_SRC  per-source ready, at most one bit high
- m_axis_tdata  out  TDATA_WIDTH  registered output data
- m_axis_tvalid  out  1  registered output valid
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  high on beat BURST_LEN of each burst
- m_axis_tid  out  ID_WIDTH  granted source index (only with AXIS_ARB_TID_EN)
- busy  out  1  high while state is GRANT

## Operation
- States: IDLE, GRANT.
- IDLE:
  - Candidate set = s_axis_tvalid & src_mask, evaluated only when enable = 1.
  - Pick the first set bit searching from last_grant+1 upward, mod NUM_SRC.
  - If one is found, register grant and last_grant, clear beat_cnt, go to GRANT.
  - Otherwise stay in IDLE.
- GRANT:
  - s_axis_tready[grant] = ~m_axis_tvalid | m_axis_tready. All other ready bits are 0.
  - Accepted beat (s_axis_tvalid[grant] & s_axis_tready[grant]):
    - load m_axis_tdata, m_axis_tvalid = 1, m_axis_tid = grant;
    - m_axis_tlast = (beat_cnt == BURST_LEN-1);
    - beat_cnt++.
  - On the accepted beat with beat_cnt == BURST_LEN-1, return to IDLE.
- Output register: m_axis_tvalid clears when m_axis_tready = 1 and no new beat loads that cycle.
- The grant is held while the granted source deasserts tvalid. There is no timeout and no early tlast.
- enable, src_mask and s_axis_tvalid of non-granted sources are ignored inside GRANT.
- beat_cnt is ceil(log2(BURST_LEN+1)) bits wide and never wraps inside a burst. last_grant wraps NUM_SRC-1 -> 0.
- Reset (m_axis_aresetn = 0 at a clock edge):
  - state = IDLE; grant = 0; last_grant = NUM_SRC-1, so source 0 is first after reset; beat_cnt = 0.
  - m_axis_tvalid = 0, m_axis_tdata = 0, m_axis_tlast = 0, m_axis_tid = 0, busy = 0.
  - s_axis_tready = 0 while reset is asserted.
  - A partial burst in flight is discarded; no tlast is emitted for it.

## Timing
- Latency: s beat accepted at edge N appears on m_axis at edge N (registered), visible cycle N+1.
- Throughput: 1 beat/cycle inside a burst.
- One idle bubble between bursts: the arbitration cycle in IDLE.
- s_axis_tready is combinational from m_axis_tready and m_axis_tvalid.
- No other combinational path from input to output.
- m_axis_tdata, m_axis_tlast and m_axis_tid are stable while m_axis_tvalid = 1 and m_axis_tready = 0.
- If the last beat is accepted and enable falls in the same cycle, the burst still ends with tlast and the next IDLE grants nothing.

## Configuration
- AXIS_ARB_TID_EN defined: m_axis_tid port exists and carries the grant index registered with each beat.
- AXIS_ARB_TID_EN undefined: m_axis_tid port and its register are absent. All other behaviour is identical.

## Structure
- Package axis_testpattern_pkg holds:
  - state typedef (IDLE, GRANT);
  - clog2-based width constants for beat_cnt and grant index.
- One sub-module: axis_rr_picker. Combinational; inputs request vector and last index; outputs found flag and next index.

## Test plan
All scenarios use NUM_SRC=2, TDATA_WIDTH=24, BURST_LEN=4, enable=1, src_mask=2'b11 unless stated. Sources are counters 1..10.
- Both sources always valid, tready=1 -> src0 beats 1,2,3,4 (tid 0, tlast on 4), one bubble, src1 beats 1..4 (tid 1), then src0 beats 5..8.
- Only src1 valid -> src1 granted repeatedly; 4 beats, 1 bubble, 4 beats; s_axis_tready[0] stays 0.
- tready=0 for 15 cycles after beat 2 -> m_axis_tdata holds 2, tvalid held, s_axis_tready=0; beats 3,4 follow with no loss or duplication.
- Reset for 1 cycle after beat 2 of src0 -> next cycle all outputs 0; first new burst is src0 with 4 full beats.
- enable=0 during beat 2 -> burst completes through tlast on beat 4, then no grant; grant to src1 one cycle after enable returns to 1.
- src_mask=2'b01 with both valid -> only src0 bursts; set mask to 2'b11 mid-burst -> src1 granted only after the current tlast.
